// File: rtl/i2c_target.sv
// I2C target on sys_clk: START/STOP detect, 7-bit address match, byte RX/TX with ACK.
// Latency 3 sys_clk pad-to-event; no clock stretching, so tx_data must be valid while tx_req=1.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h1A
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic       ack_en,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
  } state_t;

  state_t      state;
  logic [2:0]  scl_sh, sda_sh;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift, tx_shift;
  logic        rw, first_byte;

  // [0],[1] synchronize; [2] is history for edge detection. Reset to idle-bus level.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_in};
      sda_sh <= {sda_sh[1:0], sda_in};
    end
  end

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] shift_nxt;

  assign scl_rise  = scl_sh[1] & ~scl_sh[2];
  assign scl_fall  = ~scl_sh[1] & scl_sh[2];
  assign start_c   = scl_sh[1] & ~sda_sh[1] & sda_sh[2];
  assign stop_c    = scl_sh[1] & sda_sh[1] & ~sda_sh[2];
  assign shift_nxt = {shift[6:0], sda_sh[1]};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
      stop_det   <= 1'b0;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      tx_shift   <= 8'h00;
      rw         <= 1'b0;
      first_byte <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      stop_det <= 1'b0;
      if (tx_req) tx_shift <= tx_data;

      if (stop_c) begin
        state    <= S_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        bit_cnt  <= 4'd0;
      end else if (start_c) begin
        state   <= S_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rw <= sda_sh[1];
              if (shift_nxt[7:1] == ADDR) begin
                state <= S_ADDR_ACK;
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          // bit_cnt 8: ACK not yet driven; 9: ACK on the bus, next fall ends the slot.
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
                bit_cnt <= 4'd9;
              end else begin
                bit_cnt    <= 4'd0;
                first_byte <= 1'b1;
                if (rw) begin
                  state  <= S_TX;
                  sda_oe <= ~tx_shift[7];
                end else begin
                  state  <= S_RX;
                  sda_oe <= 1'b0;
                end
              end
            end else if (scl_rise && rw) begin
              tx_req <= 1'b1;
            end
          end
          S_RX: begin
            if (scl_rise) begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rx_data    <= shift_nxt;
                rx_valid   <= 1'b1;
                rx_first   <= first_byte;
                first_byte <= 1'b0;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= ack_en;
              state  <= S_RX_ACK;
            end
          end
          S_RX_ACK: if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            state   <= S_RX;
          end
          // bit_cnt 8 marks a fresh byte waiting for the ACK-slot fall to drive bit7.
          S_TX: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= ~tx_shift[7];
              bit_cnt <= 4'd0;
            end else if (bit_cnt == 4'd7) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= S_TX_ACK;
            end else begin
              sda_oe   <= ~tx_shift[6];
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          S_TX_ACK: if (scl_rise) begin
            if (!sda_sh[1]) begin
              tx_req  <= 1'b1;
              bit_cnt <= 4'd8;
              state   <= S_TX;
            end else begin
              sda_oe <= 1'b0;
              state  <= S_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master on an open-drain bus, event scoreboard.
// Expected rx_valid/tx_req/stop_det events are queued by stimulus and popped by a monitor.
module tb_i2c_target;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first;
  logic       ack_en;
  logic [7:0] tx_data;
  logic       tx_req, busy, stop_det;

  logic m_scl, m_sda_low;
  assign scl_in = m_scl;
  assign sda_in = ~(sda_oe | m_sda_low);

  i2c_target #(.ADDR(7'h1A)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_first(rx_first),
    .ack_en  (ack_en),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy),
    .stop_det(stop_det)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0] kind;   // 1 = rx byte, 2 = tx_req, 3 = stop
    logic       first;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       seen_oe, seen_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] data, input logic first);
    ev_t e;
    e.kind = kind; e.data = data; e.first = first;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data, input logic first);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h, expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || (kind == 2'd1 && (e.data !== data || e.first !== first))) begin
        errors++;
        $display("FAIL event: got kind %0d data %0h first %0b, expected kind %0d data %0h first %0b",
                 kind, data, first, e.kind, e.data, e.first);
      end
    end
  endtask

  // Monitor: scoreboard pops and flag tracking
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rx_valid === 1'b1) expect_ev(2'd1, rx_data, rx_first);
      if (tx_req === 1'b1)   expect_ev(2'd2, 8'h00, 1'b0);
      if (stop_det === 1'b1) expect_ev(2'd3, 8'h00, 1'b0);
      if (sda_oe === 1'b1) seen_oe = 1'b1;
      if (busy === 1'b1)   seen_busy = 1'b1;
    end
  end

  // Byte source answering tx_req within the same cycle
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_req === 1'b1) tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One SCL period starting and ending with SCL low; SDA sampled mid-high.
  task automatic bit_cycle(input logic drive_low, output logic seen);
    tick(4); m_sda_low = drive_low;
    tick(4); m_scl = 1'b1;
    tick(4); seen = sda_in;
    tick(4); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      tick(4); m_sda_low = 1'b0;
      tick(4); m_scl = 1'b1;
    end
    tick(8); m_sda_low = 1'b1;
    tick(8); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(4); m_sda_low = 1'b1;
    tick(4); m_scl = 1'b1;
    tick(8); m_sda_low = 1'b0;
    tick(8);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_lvl, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, s);
    check(name, {31'd0, s}, {31'd0, exp_lvl});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack, input string name);
    logic [7:0] got;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b0, s);
      got[i] = s;
    end
    check(name, {24'd0, got}, {24'd0, exp});
    bit_cycle(~nack, s);
  endtask

  initial begin
    logic s;
    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; ack_en = 1'b1; tx_data = 8'h00;
    seen_oe = 1'b0; seen_busy = 1'b0;
    tick(5);
    check("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_first", {31'd0, rx_first}, 32'd0);
    check("rst_tx_req",   {31'd0, tx_req},   32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_stop_det", {31'd0, stop_det}, 32'd0);
    rst = 1'b0;
    tick(10);

    // Address match, two written bytes
    push_ev(2'd1, 8'hA5, 1'b1); push_ev(2'd1, 8'h3C, 1'b0); push_ev(2'd3, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h34, 1'b0, "wr_addr_ack");
    check("wr_busy_on", {31'd0, busy}, 32'd1);
    write_byte(8'hA5, 1'b0, "wr_data0_ack");
    write_byte(8'h3C, 1'b0, "wr_data1_ack");
    i2c_stop();
    check("wr_busy_off", {31'd0, busy}, 32'd0);
    check("wr_rx_data", {24'd0, rx_data}, 32'h3C);

    // Address mismatch
    seen_oe = 1'b0; seen_busy = 1'b0;
    push_ev(2'd3, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h36, 1'b1, "mis_addr_nack");
    write_byte(8'hFF, 1'b1, "mis_data_nack");
    i2c_stop();
    check("mis_never_oe",   {31'd0, seen_oe},   32'd0);
    check("mis_never_busy", {31'd0, seen_busy}, 32'd0);

    // Master read, ACK then NACK
    tx_q.push_back(8'h96); tx_q.push_back(8'h0F);
    push_ev(2'd2, 8'h00, 1'b0); push_ev(2'd2, 8'h00, 1'b0); push_ev(2'd3, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h35, 1'b0, "rd_addr_ack");
    read_byte(8'h96, 1'b0, "rd_byte0");
    read_byte(8'h0F, 1'b1, "rd_byte1");
    tick(6);
    check("rd_released_after_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();

    // Data NACK with ack_en=0
    ack_en = 1'b0;
    push_ev(2'd1, 8'h55, 1'b1); push_ev(2'd3, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h34, 1'b0, "nk_addr_ack");
    write_byte(8'h55, 1'b1, "nk_data_nack");
    i2c_stop();
    ack_en = 1'b1;

    // Repeated START: write then read
    tx_q.push_back(8'hC3);
    push_ev(2'd1, 8'h10, 1'b1); push_ev(2'd2, 8'h00, 1'b0); push_ev(2'd3, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h34, 1'b0, "rs_addr0_ack");
    write_byte(8'h10, 1'b0, "rs_data_ack");
    i2c_start();
    write_byte(8'h35, 1'b0, "rs_addr1_ack");
    check("rs_busy", {31'd0, busy}, 32'd1);
    read_byte(8'hC3, 1'b1, "rs_read");
    check("rs_rx_data", {24'd0, rx_data}, 32'h10);
    i2c_stop();

    // STOP after 4 data bits
    push_ev(2'd3, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h34, 1'b0, "ab_addr_ack");
    bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s);
    i2c_stop();
    check("ab_busy_off", {31'd0, busy}, 32'd0);

    // Reset during TX
    tx_q.push_back(8'h00);
    push_ev(2'd2, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h35, 1'b0, "rt_addr_ack");
    bit_cycle(1'b0, s); bit_cycle(1'b0, s);
    tick(4);
    check("rt_driving", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("rt_sda_oe",  {31'd0, sda_oe},  32'd0);
    check("rt_busy",    {31'd0, busy},    32'd0);
    check("rt_rx_data", {24'd0, rx_data}, 32'd0);
    check("rt_rx_first",{31'd0, rx_first},32'd0);
    check("rt_tx_req",  {31'd0, tx_req},  32'd0);
    rst = 1'b0;
    tick(4);
    push_ev(2'd3, 8'h00, 1'b0);
    i2c_stop();

    tick(20);
    check("events_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the bus end opposite our i2c master.
- Detects START/STOP, matches a 7-bit address and ACKs it.
- Master-write: receives bytes and ACKs them. Master-read: transmits bytes.
- Sits on the same open-drain SDA/SCL pair as the master. Used as the board-side loopback target and as the bus model for master verification; all logic on sys_clk.

Parameters:
ADDR, 7'h1A, 7-bit target address this block responds to.

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
scl_in  in  1  SCL pad input (asynchronous)
sda_in  in  1  SDA pad input (asynchronous)
sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z); pad drives only 0
rx_data  out  8  last byte received from master
rx_valid  out  1  1-cycle pulse: rx_data updated
rx_first  out  1  qualifies rx_valid: first data byte after address
ack_en  in  1  1 = ACK received data bytes; 0 = NACK them
tx_data  in  8  next byte to send; sampled in the cycle tx_req=1
tx_req  out  1  1-cycle pulse: block latches tx_data this cycle
busy  out  1  1 from addressed START until STOP or mismatch
stop_det  out  1  1-cycle pulse on every STOP condition

Behaviour:
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus a third history flop.
  - Edge and START/STOP events are decoded from the synchronized signals; event latency is 3 sys_clk from the pad.
  - Bus timing requirement: SCL high and low phases >= 6 sys_clk. No clock stretching.
- Events:
  - START = synced SDA falls while synced SCL high.
  - STOP = synced SDA rises while synced SCL high.
  - Data is sampled on synced SCL rise. sda_oe changes only in the cycle synced SCL fall is detected.
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_req=0, busy=0, stop_det=0; state IDLE; bit counter 0; shift registers 0.
- Reset mid-transfer: bus released the next cycle; the transfer is abandoned.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first on SCL rises; bit 8 is R/W.
    - After the 8th rise: if addr[7:1]==ADDR, go to ADDR_ACK; else go to IGNORE.
  - ADDR_ACK: at the next SCL fall, sda_oe=1 and busy=1.
    - If R/W=1: tx_req pulses on the 9th SCL rise; the byte is latched into the TX shifter.
    - At the 9th SCL fall: R/W=0 goes to RX with sda_oe=0; R/W=1 goes to TX with sda_oe=~bit7.
  - RX: shift 8 bits on SCL rises.
    - After the 8th rise: rx_data loads, rx_valid pulses, rx_first=1 if this is the first byte since the address.
    - At the next fall, sda_oe=ack_en (value sampled at that fall). Go to RX_ACK.
  - RX_ACK: at the 9th fall, sda_oe=0 and go back to RX.
  - TX: on each SCL fall, drive the next bit with sda_oe=~bit (bits 6..0 after bit7).
    - After the 8th fall following the start of bit7, sda_oe=0 and go to TX_ACK.
  - TX_ACK: sample SDA on the 9th rise.
    - 0 (ACK): tx_req pulses that same cycle, new byte latched, go to TX; bit7 is driven on the 9th fall.
    - 1 (NACK): go to IGNORE with sda_oe=0.
  - IGNORE: sda_oe=0; wait for START or STOP.
- START in any state (repeated START): sda_oe=0, bit counter=0, go to ADDR. busy keeps its value until the address result.
- STOP in any state: sda_oe=0, busy=0, stop_det pulses, go to IDLE. A partial byte is discarded with no rx_valid.
- START/STOP detection has priority over SCL-edge processing in the same cycle.
- General-call address 0 is not matched unless ADDR=0.
- Bit counter is 4 bits and wraps to 0 after each ACK slot.

Test Plan:
- Address match write: START, 0x34 (0x1A,W), data 0xA5, 0x3C, STOP with ack_en=1 -> SDA low in all three ACK slots; rx_valid twice with rx_data=0xA5 (rx_first=1) then 0x3C (rx_first=0); stop_det once; busy 1 then 0.
- Address mismatch: START, 0x36, 0xFF, STOP -> sda_oe never 1; no rx_valid; busy stays 0; stop_det pulses.
- Master read: START, 0x35, tx_data=0x96 then 0x0F, master ACKs the first byte and NACKs the second, then STOP -> bus bits 1,0,0,1,0,1,1,0 then 0,0,0,0,1,1,1,1; two tx_req pulses; sda_oe=0 after the NACK.
- NACK data: ack_en=0, START, 0x34, 0x55 -> address slot ACKed; data ACK slot left high; rx_valid still pulses with 0x55.
- Repeated START: START, 0x34, 0x10, START, 0x35, read 0xC3, NACK, STOP -> rx_data=0x10; second address ACKed; 0xC3 shifted out; no stop_det before the final STOP.
- Aborts:
  - STOP after 4 data bits -> IDLE, no rx_valid.
  - rst asserted during TX -> sda_oe=0 the next cycle; all outputs at reset values.
